// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// Carries {pc, inst} from fetch to decode. Flush empties the buffer and shows a NOP bubble.
module if_id_skid_reg #(
   parameter int unsigned       PC_W     = 32,
   parameter int unsigned       INST_W   = 32,
   parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013),
   parameter logic [PC_W-1:0]   RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [INST_W-1:0] in_inst,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [INST_W-1:0] out_inst,
   output logic [1:0]        count
);

   // The state encoding equals the occupancy, so count is the state register.
   localparam logic [1:0] StEmpty = 2'd0;
   localparam logic [1:0] StOne   = 2'd1;
   localparam logic [1:0] StFull  = 2'd2;

   logic [1:0]        state_q, state_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic [PC_W-1:0]   main_pc_q, main_pc_d;
   logic [INST_W-1:0] main_inst_q, main_inst_d;
   logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
   logic [INST_W-1:0] skid_inst_q, skid_inst_d;
   logic              in_xfer, out_xfer;

   assign in_xfer  = in_valid & in_ready_q;
   assign out_xfer = out_valid_q & out_ready;

   // Next-state and datapath steering; flush overrides and keeps the head so out_pc holds.
   always_comb begin
      state_d     = state_q;
      main_pc_d   = main_pc_q;
      main_inst_d = main_inst_q;
      skid_pc_d   = skid_pc_q;
      skid_inst_d = skid_inst_q;
      if (flush) begin
         state_d = StEmpty;
      end else begin
         case (state_q)
            StEmpty: begin
               if (in_xfer) begin
                  state_d     = StOne;
                  main_pc_d   = in_pc;
                  main_inst_d = in_inst;
               end
            end
            StOne: begin
               if (in_xfer && !out_xfer) begin
                  state_d     = StFull;
                  skid_pc_d   = in_pc;
                  skid_inst_d = in_inst;
               end else if (!in_xfer && out_xfer) begin
                  state_d = StEmpty;
               end else if (in_xfer && out_xfer) begin
                  main_pc_d   = in_pc;
                  main_inst_d = in_inst;
               end
            end
            StFull: begin
               if (out_xfer) begin
                  state_d     = StOne;
                  main_pc_d   = skid_pc_q;
                  main_inst_d = skid_inst_q;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
      in_ready_d  = (state_d != StFull);
      out_valid_d = (state_d != StEmpty);
   end

   // State, handshake flags and entry storage; reset discards both entries at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StEmpty;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         main_pc_q   <= RESET_PC;
         main_inst_q <= NOP_INST;
         skid_pc_q   <= RESET_PC;
         skid_inst_q <= NOP_INST;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         main_pc_q   <= main_pc_d;
         main_inst_q <= main_inst_d;
         skid_pc_q   <= skid_pc_d;
         skid_inst_q <= skid_inst_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_pc    = main_pc_q;
   assign out_inst  = out_valid_q ? main_inst_q : NOP_INST;
   assign count     = state_q;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Self-checking bench for if_id_skid_reg: vector table, corner sequences, random vs. queue model.
module tb_if_id_skid_reg;

   logic        clk;
   logic        rst;
   logic        in_valid, flush, out_ready;
   logic [31:0] in_pc, in_inst;
   logic        in_ready, out_valid;
   logic [31:0] out_pc, out_inst;
   logic [1:0]  count;

   // Wide-PC / narrow-instruction instance
   logic        w_in_valid, w_flush, w_out_ready;
   logic [63:0] w_in_pc, w_out_pc;
   logic [15:0] w_in_inst, w_out_inst;
   logic        w_in_ready, w_out_valid;
   logic [1:0]  w_count;

   int n_cmp = 0;
   int n_err = 0;

   if_id_skid_reg dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_inst(in_inst), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_inst(out_inst), .count(count)
   );

   if_id_skid_reg #(.PC_W(64), .INST_W(16), .NOP_INST(16'h0013), .RESET_PC(64'd0)) dut_w (
      .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_pc(w_in_pc),
      .in_inst(w_in_inst), .flush(w_flush), .out_valid(w_out_valid), .out_ready(w_out_ready),
      .out_pc(w_out_pc), .out_inst(w_out_inst), .count(w_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic ev, input logic er, input logic [1:0] ec,
                            input logic [31:0] ep, input logic [31:0] ei);
      check({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
      check({tag, ".in_ready"},  64'(in_ready),  64'(er));
      check({tag, ".count"},     64'(count),     64'(ec));
      check({tag, ".out_pc"},    64'(out_pc),    64'(ep));
      check({tag, ".out_inst"},  64'(out_inst),  64'(ei));
   endtask

   typedef struct {
      logic        iv;
      logic [31:0] pc;
      logic [31:0] inst;
      logic        fl;
      logic        ordy;
      logic        ev;
      logic        er;
      logic [1:0]  ec;
      logic [31:0] ep;
      logic [31:0] ei;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   // Reference model: FIFO of accepted entries plus the last head PC shown on out_pc
   ent_t        mq[$];
   logic [31:0] m_last_pc;

   task automatic model_edge();
      logic ix, ox;
      ix = in_valid && (mq.size() < 2);
      ox = (mq.size() > 0) && out_ready;
      if (flush) mq.delete();
      else begin
         if (ox) void'(mq.pop_front());
         if (ix) mq.push_back('{pc: in_pc, inst: in_inst});
      end
      if (mq.size() > 0) m_last_pc = mq[0].pc;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      mq.delete();
      m_last_pc = 32'h0;
   endtask

   vec_t vt[15];

   initial begin
      rst = 1'b0;
      in_valid = 0; flush = 0; out_ready = 0; in_pc = 0; in_inst = 0;
      w_in_valid = 0; w_flush = 0; w_out_ready = 0; w_in_pc = 0; w_in_inst = 0;
      m_last_pc = 0;

      // 1. Reset then idle
      do_reset();
      check_all("reset", 0, 1, 0, 32'h0, 32'h13);
      step();
      check_all("idle", 0, 1, 0, 32'h0, 32'h13);

      //        iv  pc        inst      fl ordy ev er ec ep        ei
      vt[0]  = '{1, 32'h0,   32'hA,    0, 1,   1, 1, 1, 32'h0,   32'hA};
      vt[1]  = '{1, 32'h4,   32'h32,   0, 1,   1, 1, 1, 32'h4,   32'h32};
      vt[2]  = '{1, 32'h8,   32'hA,    0, 1,   1, 1, 1, 32'h8,   32'hA};
      vt[3]  = '{0, 32'h0,   32'h0,    0, 1,   0, 1, 0, 32'h8,   32'h13};
      vt[4]  = '{1, 32'h5,   32'h32,   0, 0,   1, 1, 1, 32'h5,   32'h32};
      vt[5]  = '{1, 32'h10,  32'hA,    0, 0,   1, 0, 2, 32'h5,   32'h32};
      vt[6]  = '{1, 32'h99,  32'h99,   0, 0,   1, 0, 2, 32'h5,   32'h32};
      vt[7]  = '{0, 32'h0,   32'h0,    0, 1,   1, 1, 1, 32'h10,  32'hA};
      vt[8]  = '{0, 32'h0,   32'h0,    0, 1,   0, 1, 0, 32'h10,  32'h13};
      vt[9]  = '{1, 32'h40,  32'h1,    0, 0,   1, 1, 1, 32'h40,  32'h1};
      vt[10] = '{1, 32'h44,  32'h2,    0, 0,   1, 0, 2, 32'h40,  32'h1};
      vt[11] = '{1, 32'h20,  32'h3,    1, 0,   0, 1, 0, 32'h40,  32'h13};
      vt[12] = '{0, 32'h0,   32'h0,    1, 0,   0, 1, 0, 32'h40,  32'h13};
      vt[13] = '{1, 32'h50,  32'h5,    0, 0,   1, 1, 1, 32'h50,  32'h5};
      vt[14] = '{1, 32'h54,  32'h6,    1, 1,   0, 1, 0, 32'h50,  32'h13};

      // 2-4. Streaming, backpressure, flush
      for (int i = 0; i < 15; i++) begin
         in_valid = vt[i].iv; in_pc = vt[i].pc; in_inst = vt[i].inst;
         flush = vt[i].fl; out_ready = vt[i].ordy;
         step();
         check_all($sformatf("vec%0d", i), vt[i].ev, vt[i].er, vt[i].ec, vt[i].ep, vt[i].ei);
      end
      in_valid = 0; flush = 0; out_ready = 0;

      // 5. Async reset mid-stream
      in_valid = 1; in_pc = 32'h60; in_inst = 32'h61;
      step();
      in_pc = 32'h64; in_inst = 32'h65;
      step();
      in_valid = 0;
      check_all("pre_async", 1, 0, 2, 32'h60, 32'h61);
      #2 rst = 1'b0;
      #1 check_all("async_rst", 0, 1, 0, 32'h0, 32'h13);
      @(negedge clk);
      check_all("rst_held", 0, 1, 0, 32'h0, 32'h13);
      rst = 1'b1;
      in_valid = 1; in_pc = 32'h30; in_inst = 32'h31; out_ready = 1;
      step();
      check_all("post_rst", 1, 1, 1, 32'h30, 32'h31);
      in_valid = 0;
      step();
      check_all("post_rst_drain", 0, 1, 0, 32'h30, 32'h13);
      out_ready = 0;

      // 6. Wide parameter instance
      w_in_valid = 1; w_in_pc = 64'hFFFF_FFFF_FFFF_FFFF; w_in_inst = 16'hBEEF;
      step();
      w_in_pc = 64'h8000_0000_0000_0001; w_in_inst = 16'h1234;
      check("w.out_pc0", w_out_pc, 64'hFFFF_FFFF_FFFF_FFFF);
      check("w.out_inst0", 64'(w_out_inst), 64'hBEEF);
      w_out_ready = 1;
      step();
      w_in_valid = 0;
      check("w.out_pc1", w_out_pc, 64'h8000_0000_0000_0001);
      check("w.out_inst1", 64'(w_out_inst), 64'h1234);
      step();
      check("w.out_inst_nop", 64'(w_out_inst), 64'h0013);
      check("w.count", 64'(w_count), 64'd0);

      // Randomised traffic against the queue model
      do_reset();
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         in_pc     = $urandom;
         in_inst   = $urandom;
         @(posedge clk);
         model_edge();
         @(negedge clk);
         check_all($sformatf("rnd%0d", i), mq.size() > 0, mq.size() < 2, 2'(mq.size()),
                   m_last_pc, (mq.size() > 0) ? mq[0].inst : 32'h13);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
- Parametrised successor to the fixed 64-bit fetch pipeline register.
- Sits between the fetch and decode stages and carries a {pc, inst} pair.
- Replaces the simple enable/stall input with a valid/ready handshake backed by a 2-entry skid buffer.
- Adds a synchronous flush that injects a NOP bubble on branch or jump redirect.

Parameters:
- PC_W, 32, width of the program-counter field.
- INST_W, 32, width of the instruction field.
- NOP_INST, 32'h0000_0013, instruction driven on out_inst when out_valid=0 (addi x0,x0,0).
- RESET_PC, 32'h0000_0000, value of out_pc after reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  fetch presents a valid pc/inst pair.
- in_ready  output  1  buffer can accept an entry; registered.
- in_pc  input  PC_W  fetched PC.
- in_inst  input  INST_W  fetched instruction.
- flush  input  1  synchronous discard of all held entries.
- out_valid  output  1  decode side holds a valid entry.
- out_ready  input  1  decode accepts the current entry.
- out_pc  output  PC_W  PC of the head entry.
- out_inst  output  INST_W  instruction of the head entry, or NOP_INST.
- count  output  2  occupancy, 0..2.

Behaviour:
- Reset (rst=0, asynchronous, effective immediately, including mid-transfer):
  - state=EMPTY, out_valid=0, in_ready=1, count=0.
  - out_pc=RESET_PC, out_inst=NOP_INST.
  - Both entries are discarded.
- Handshakes:
  - in_xfer = in_valid & in_ready.
  - out_xfer = out_valid & out_ready.
  - Both are evaluated at the rising clock edge.
- Storage: a main register (the head, driving outputs) and a skid register.
- States and count:
  - EMPTY (count 0), ONE (count 1, main valid), FULL (count 2, main and skid valid).
- Transitions, with flush=0:
  - EMPTY: in_xfer -> ONE, main<=in. Otherwise stay EMPTY.
  - ONE:
    - in_xfer & !out_xfer -> FULL, skid<=in.
    - !in_xfer & out_xfer -> EMPTY.
    - in_xfer & out_xfer -> ONE, main<=in.
    - Neither -> hold.
  - FULL: in_ready=0, so no in_xfer is possible.
    - out_xfer -> ONE, main<=skid.
    - Otherwise hold.
- Register updates:
  - in_ready is registered: next value = (next_state != FULL).
  - count and out_valid are registered and change only on clock edges.
- Latency and ordering:
  - An accepted entry appears on out_* one cycle after in_xfer, when the buffer was empty or drained in the same cycle.
  - Strict FIFO order; no entry is dropped or duplicated except by flush or reset.
  - Sustained in_valid=out_ready=1 gives 1 entry/cycle throughput.
- Stability: while out_valid=1 and out_ready=0, out_pc and out_inst must not change.
- Bubble outputs:
  - When out_valid=0, out_inst=NOP_INST.
  - out_pc holds its last valid value (RESET_PC after reset).
- Flush (flush=1 at an edge):
  - Highest priority among synchronous events.
  - Next state=EMPTY, out_valid=0, in_ready=1, count=0.
  - Any in_xfer in the same cycle is discarded.
  - An out_xfer in the same cycle still counts as consumed by decode.
- Flush while EMPTY: no effect other than holding EMPTY.
- Simultaneous flush and reset: reset dominates.
- Width rule: fields are stored verbatim with no sign or zero extension; PC_W and INST_W are independent.

Test Plan:
1. Reset then idle:
   - Stimulus: rst=0 for 2 cycles, then rst=1.
   - Required: out_valid=0, in_ready=1, count=0, out_pc=0, out_inst=0x00000013.
2. Streaming:
   - Stimulus: in_valid=1, out_ready=1; pc=0x0,0x4,0x8 with inst=0xA,0x32,0xA on successive cycles.
   - Required: each pair appears one cycle later in order; count stays 1.
3. Backpressure fill:
   - Stimulus: out_ready=0; push pc=0x5/inst=0x32, then pc=0x10/inst=0xA.
   - Required: count goes 1 then 2 and in_ready=0. out_pc stays 0x5 throughout.
   - Then raise out_ready: observe 0x5, then 0x10, and in_ready=1 one cycle after the first pop.
4. Flush while full:
   - Stimulus: with count=2, assert flush=1 together with in_valid=1 (pc=0x20).
   - Required next cycle: count=0, out_valid=0, out_inst=0x13; 0x20 is never output.
5. Async reset mid-stream:
   - Stimulus: with count=2, drop rst between clock edges.
   - Required: outputs reach reset values immediately, without waiting for a clock edge; after release, the first pushed pc=0x30 emerges correctly.
6. Parameter sweep:
   - Stimulus: PC_W=64, INST_W=16; push pc=0xFFFF_FFFF_FFFF_FFFF, inst=0xBEEF.
   - Required: values are reproduced bit-exact on out_pc and out_inst.
